// File: rtl/regfile_wb_pkg.sv
//==============================================================================
// Package : cpu_pkg
// Brief   : Shared widths, special register numbers and the write-back hit helper.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

package cpu_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int NREG   = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

    // True when this cycle's write-back targets register a.
    function automatic logic wb_hits(input logic we,
                                     input logic [ADDR_W-1:0] waddr,
                                     input logic [ADDR_W-1:0] a);
        return we && (waddr == a);
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_wb_if.sv
//==============================================================================
// Interface : regfile_wb_if
// Brief     : Decode / write-back side bundle of the register file.
// Rev       : 1.0  initial release
//==============================================================================
`default_nettype none

interface regfile_wb_if;
    import cpu_pkg::*;

    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic              resv;
    logic [ADDR_W-1:0] resv_addr;
    logic              stall;
    logic [NREG-1:0]   busy;
    logic [ADDR_W:0]   pending;

    modport master (
        output we, waddr, wdata, raddr1, raddr2, resv, resv_addr,
        input  rdata1, rdata2, stall, busy, pending
    );

    modport slave (
        input  we, waddr, wdata, raddr1, raddr2, resv, resv_addr,
        output rdata1, rdata2, stall, busy, pending
    );

endinterface

`default_nettype wire

// File: rtl/regfile_wb_rf_scoreboard.sv
//==============================================================================
// Module : rf_scoreboard
// Brief  : Per-register busy bits, pending count and decode stall generation.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module rf_scoreboard
    import cpu_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              we,
    input  wire logic [ADDR_W-1:0] waddr,
    input  wire logic [ADDR_W-1:0] raddr1,
    input  wire logic [ADDR_W-1:0] raddr2,
    input  wire logic              resv,
    input  wire logic [ADDR_W-1:0] resv_addr,
    output logic                   stall,
    output logic [NREG-1:0]        busy,
    output logic [ADDR_W:0]        pending
);

    logic [NREG-1:0] busy_q,    busy_d;
    logic [ADDR_W:0] pending_q, pending_d;
    logic            set_take;
    logic            inc;
    logic            dec;

    always_comb begin
        stall = (busy_q[raddr1] && !wb_hits(we, waddr, raddr1))
              | (busy_q[raddr2] && !wb_hits(we, waddr, raddr2))
              | (resv && busy_q[resv_addr] && !wb_hits(we, waddr, resv_addr));

        set_take = resv && !stall && (resv_addr != REG_ZERO);

        busy_d = busy_q;
        if (we)
            busy_d[waddr] = 1'b0;
        if (set_take)
            busy_d[resv_addr] = 1'b1;
        busy_d[REG_ZERO] = 1'b0;

        // Count only real bit transitions so pending tracks popcount(busy) even
        // when a reservation lands on a register being released this cycle.
        inc = set_take && !busy_q[resv_addr];
        dec = we && busy_q[waddr] && !(set_take && (resv_addr == waddr));
        pending_d = pending_q + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= '0;
            pending_q <= '0;
        end else begin
            busy_q    <= busy_d;
            pending_q <= pending_d;
        end
    end

    assign busy    = busy_q;
    assign pending = pending_q;

endmodule

`default_nettype wire

// File: rtl/regfile_wb.sv
//==============================================================================
// Module : regfile_wb
// Brief  : 32x32 register file with write-through bypass and busy scoreboard.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module regfile_wb
    import cpu_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     rst_n,
    regfile_wb_if.slave   bus
);

    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra,
                                                     input logic [DATA_W-1:0] stored);
        if (ra == REG_ZERO)
            return '0;
        else if (wb_hits(bus.we, bus.waddr, ra))
            return bus.wdata;
        else
            return stored;
    endfunction

    always_comb begin
        regs_d = regs_q;
        if (bus.we && (bus.waddr != REG_ZERO))
            regs_d[bus.waddr] = bus.wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        bus.rdata1 = read_port(bus.raddr1, regs_q[bus.raddr1]);
        bus.rdata2 = read_port(bus.raddr2, regs_q[bus.raddr2]);
    end

    rf_scoreboard u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (bus.we),
        .waddr     (bus.waddr),
        .raddr1    (bus.raddr1),
        .raddr2    (bus.raddr2),
        .resv      (bus.resv),
        .resv_addr (bus.resv_addr),
        .stall     (bus.stall),
        .busy      (bus.busy),
        .pending   (bus.pending)
    );

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb.sv
//==============================================================================
// Module : tb_regfile_wb
// Brief  : Directed bench with a reference model compared every cycle.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_regfile_wb;
    import cpu_pkg::*;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    bit   cmp_en = 0;

    regfile_wb_if bus ();

    regfile_wb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Reference state: architectural register contents and outstanding reservations.
    logic [31:0] m_regs [32];
    bit          m_busy [32];

    function automatic bit hazard(input logic [4:0] a);
        return (a != 0) && m_busy[a] && !(bus.we && bus.waddr == a);
    endfunction

    function automatic bit exp_stall();
        return hazard(bus.raddr1) || hazard(bus.raddr2) || (bus.resv && hazard(bus.resv_addr));
    endfunction

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (bus.we && bus.waddr == a) return bus.wdata;
        return m_regs[a];
    endfunction

    function automatic logic [31:0] exp_busy();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic int exp_pending();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] <= '0;
                m_busy[i] <= 0;
            end
        end else begin
            automatic bit take = bus.resv && !exp_stall() && bus.resv_addr != 0;
            if (bus.we && bus.waddr != 0) m_regs[bus.waddr] <= bus.wdata;
            for (int i = 1; i < 32; i++) begin
                if (take && bus.resv_addr == i)        m_busy[i] <= 1;
                else if (bus.we && bus.waddr == i)     m_busy[i] <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_rdata1",  bus.rdata1, exp_rd(bus.raddr1));
            check("cyc_rdata2",  bus.rdata2, exp_rd(bus.raddr2));
            check("cyc_stall",   {31'b0, bus.stall}, {31'b0, exp_stall()});
            check("cyc_busy",    bus.busy, exp_busy());
            check("cyc_pending", {26'b0, bus.pending}, 32'(exp_pending()));
        end
    end

    // Drives one cycle worth of inputs shortly after the rising edge.
    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2,
                         input logic rv, input logic [4:0] ra);
        @(posedge clk);
        #1;
        bus.we = we; bus.waddr = wa; bus.wdata = wd;
        bus.raddr1 = r1; bus.raddr2 = r2;
        bus.resv = rv; bus.resv_addr = ra;
        #1;
    endtask

    initial begin
        rst_n = 0;
        bus.we = 0; bus.waddr = 0; bus.wdata = 0;
        bus.raddr1 = 0; bus.raddr2 = 0; bus.resv = 0; bus.resv_addr = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        cmp_en = 1;
        #1;
        check("reset_busy",    bus.busy, 32'h0);
        check("reset_pending", {26'b0, bus.pending}, 32'h0);
        check("reset_stall",   {31'b0, bus.stall}, 32'h0);

        // Plain write then read; register 0 reads zero.
        drive(1, 5, 32'h1234_5678, 0, 0, 0, 0);
        drive(0, 0, 0, 5, 0, 0, 0);
        check("t1_rdata1", bus.rdata1, 32'h1234_5678);
        check("t1_rdata2", bus.rdata2, 32'h0);

        // Writes to register 0 are dropped.
        drive(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        check("t2_bypass_r0", bus.rdata1, 32'h0);
        drive(0, 0, 0, 0, 5, 0, 0);
        check("t2_r0", bus.rdata1, 32'h0);
        check("t2_busy0", {31'b0, bus.busy[0]}, 32'h0);

        // Bypass before the edge, then the stored value.
        drive(1, 7, 32'hA5A5_A5A5, 0, 7, 0, 0);
        check("t3_bypass", bus.rdata2, 32'hA5A5_A5A5);
        drive(0, 0, 0, 0, 7, 0, 0);
        check("t3_stored", bus.rdata2, 32'hA5A5_A5A5);

        // Reserve $31, stall on read until write-back, then release.
        drive(0, 0, 0, 0, 0, 1, REG_RA);
        drive(0, 0, 0, 31, 0, 0, 0);
        check("t4_busy31", {31'b0, bus.busy[31]}, 32'h1);
        check("t4_pending", {26'b0, bus.pending}, 32'h1);
        check("t4_stall", {31'b0, bus.stall}, 32'h1);
        drive(0, 0, 0, 31, 0, 0, 0);
        check("t4_stall_hold", {31'b0, bus.stall}, 32'h1);
        drive(1, 31, 32'hDEAD_BEEF, 31, 0, 0, 0);
        check("t4_wb_stall", {31'b0, bus.stall}, 32'h0);
        check("t4_wb_rdata1", bus.rdata1, 32'hDEAD_BEEF);
        drive(0, 0, 0, 31, 0, 0, 0);
        check("t4_busy31_clr", {31'b0, bus.busy[31]}, 32'h0);
        check("t4_pending_clr", {26'b0, bus.pending}, 32'h0);

        // Re-reserve on the write-back cycle: set wins, count unchanged.
        drive(0, 0, 0, 0, 0, 1, 9);
        drive(1, 9, 32'h0000_0099, 0, 0, 1, 9);
        check("t5_stall", {31'b0, bus.stall}, 32'h0);
        drive(0, 0, 0, 0, 0, 1, 9);
        check("t5_busy9", {31'b0, bus.busy[9]}, 32'h1);
        check("t5_pending", {26'b0, bus.pending}, 32'h1);
        check("t5_resv_busy_stall", {31'b0, bus.stall}, 32'h1);
        drive(0, 0, 0, 0, 0, 1, 0);
        drive(1, 9, 32'h0000_0100, 9, 9, 0, 0);
        drive(0, 0, 0, 9, 0, 0, 0);
        check("t5_released", {26'b0, bus.pending}, 32'h0);
        check("t5_rdata", bus.rdata1, 32'h0000_0100);

        // Reserve $2..$4, then asynchronous reset between edges.
        drive(0, 0, 0, 0, 0, 1, 2);
        drive(0, 0, 0, 0, 0, 1, 3);
        drive(0, 0, 0, 0, 0, 1, 4);
        drive(0, 0, 0, 5, 7, 0, 0);
        check("t6_pending3", {26'b0, bus.pending}, 32'h3);
        check("t6_busy", bus.busy, 32'h0000_001C);
        #1 rst_n = 0;
        #1;
        check("t6_rst_busy", bus.busy, 32'h0);
        check("t6_rst_pending", {26'b0, bus.pending}, 32'h0);
        check("t6_rst_r5", bus.rdata1, 32'h0);
        check("t6_rst_r7", bus.rdata2, 32'h0);
        @(posedge clk);
        #1 rst_n = 1;

        // Write-back after reset writes data but leaves busy clear.
        drive(1, 3, 32'hCAFE_0003, 0, 0, 0, 0);
        drive(0, 0, 0, 3, 0, 0, 0);
        check("t6_post_wr", bus.rdata1, 32'hCAFE_0003);
        check("t6_post_busy", bus.busy, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 cmp_en = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
